// File: rtl/led_pattern_pkg.sv
// Shared mode type and helpers for the multi-channel LED pattern generator.
// Mode 4 (BREATHE) decodes only when LED_BREATHE_EN is defined.
package led_pattern_pkg;

   typedef enum logic [2:0] {
      LED_OFF     = 3'd0,
      LED_ON      = 3'd1,
      LED_BLINK   = 3'd2,
      LED_PWM     = 3'd3,
      LED_BREATHE = 3'd4
   } led_mode_t;

   function automatic int calc_tick_div(input int clk_freq_hz, input int tick_hz);
      return clk_freq_hz / tick_hz;
   endfunction

   // Unknown codes fall back to OFF so a bad write can never light an LED.
   function automatic led_mode_t decode_mode(input logic [2:0] code);
      led_mode_t mode_s;
      case (code)
         3'd0:    mode_s = LED_OFF;
         3'd1:    mode_s = LED_ON;
         3'd2:    mode_s = LED_BLINK;
         3'd3:    mode_s = LED_PWM;
`ifdef LED_BREATHE_EN
         3'd4:    mode_s = LED_BREATHE;
`else
         3'd4:    mode_s = LED_OFF;
`endif
         default: mode_s = LED_OFF;
      endcase
      return mode_s;
   endfunction

endpackage

// File: rtl/led_pattern_gen_chan.sv
// One LED channel: config registers, phase counter, blink state and optional
// breathe ramp (LED_BREATHE_EN), with a registered LED drive.
module led_chan
   import led_pattern_pkg::*;
#(
   parameter int PER_W  = 16,
   parameter int DUTY_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [DUTY_W-1:0] pwm_cnt,
   input  logic              wr_en,
   input  logic [2:0]        wr_mode,
   input  logic [PER_W-1:0]  wr_period,
   input  logic [DUTY_W-1:0] wr_duty,
   output logic              led
);

   led_mode_t         mode_r;
   logic [PER_W-1:0]  period_r;
   logic [DUTY_W-1:0] duty_r;
   logic [PER_W-1:0]  cnt_r;
   logic              blink_r;
   logic              led_r;
   logic [PER_W-1:0]  eff_per_s;
   logic              count_en_s;
   logic              per_done_s;
   logic              led_nxt_s;
   logic [DUTY_W-1:0] ramp_s;

   assign eff_per_s  = (period_r == {PER_W{1'b0}}) ? PER_W'(1) : period_r;
   assign count_en_s = tick && !wr_en && ((mode_r == LED_BLINK) || (mode_r == LED_BREATHE));
   assign per_done_s = (cnt_r == (eff_per_s - PER_W'(1)));

   // Config capture and phase counting; a write overrides a coincident tick
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_r   <= LED_OFF;
         period_r <= {PER_W{1'b0}};
         duty_r   <= {DUTY_W{1'b0}};
         cnt_r    <= {PER_W{1'b0}};
         blink_r  <= 1'b0;
      end else if (wr_en) begin
         mode_r   <= decode_mode(wr_mode);
         period_r <= wr_period;
         duty_r   <= wr_duty;
         cnt_r    <= {PER_W{1'b0}};
         blink_r  <= 1'b1;
      end else if (count_en_s) begin
         if (per_done_s) begin
            cnt_r   <= {PER_W{1'b0}};
            blink_r <= ~blink_r;
         end else begin
            cnt_r   <= cnt_r + PER_W'(1);
         end
      end
   end

`ifdef LED_BREATHE_EN
   localparam logic [DUTY_W-1:0] RAMP_MAX = {DUTY_W{1'b1}};
   logic [DUTY_W-1:0] ramp_r;
   logic              ramp_up_r;

   // Triangle ramp: one duty step per completed period, reversing at each end
   always_ff @(posedge clk) begin
      if (rst || wr_en) begin
         ramp_r    <= {DUTY_W{1'b0}};
         ramp_up_r <= 1'b1;
      end else if (count_en_s && per_done_s && (mode_r == LED_BREATHE)) begin
         if (ramp_up_r) begin
            if (ramp_r == RAMP_MAX) begin
               ramp_up_r <= 1'b0;
               ramp_r    <= ramp_r - DUTY_W'(1);
            end else begin
               ramp_r    <= ramp_r + DUTY_W'(1);
            end
         end else begin
            if (ramp_r == {DUTY_W{1'b0}}) begin
               ramp_up_r <= 1'b1;
               ramp_r    <= ramp_r + DUTY_W'(1);
            end else begin
               ramp_r    <= ramp_r - DUTY_W'(1);
            end
         end
      end
   end

   assign ramp_s = ramp_r;
`else
   assign ramp_s = {DUTY_W{1'b0}};
`endif

   // Output level selected by the active mode
   always_comb begin
      led_nxt_s = 1'b0;
      case (mode_r)
         LED_OFF:     led_nxt_s = 1'b0;
         LED_ON:      led_nxt_s = 1'b1;
         LED_BLINK:   led_nxt_s = blink_r;
         LED_PWM:     led_nxt_s = (duty_r > pwm_cnt);
         LED_BREATHE: led_nxt_s = (ramp_s > pwm_cnt);
         default:     led_nxt_s = 1'b0;
      endcase
   end

   // Registered LED drive
   always_ff @(posedge clk) begin
      if (rst) begin
         led_r <= 1'b0;
      end else begin
         led_r <= led_nxt_s;
      end
   end

   assign led = led_r;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator top: shared prescaler, PWM frame counter,
// ready flag and write decode. Optional BREATHE mode via LED_BREATHE_EN.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 1_000,
   parameter int NUM_CH      = 4,
   parameter int PER_W       = 16,
   parameter int DUTY_W      = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          cfg_valid,
   output logic                                          cfg_ready,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_chan,
   input  logic [2:0]                                    cfg_mode,
   input  logic [PER_W-1:0]                              cfg_period,
   input  logic [DUTY_W-1:0]                             cfg_duty,
   output logic [NUM_CH-1:0]                             led_out
);

   localparam int TICK_DIV = calc_tick_div(CLK_FREQ_HZ, TICK_HZ);
   localparam int PRESC_W  = $clog2(TICK_DIV);
   localparam int CHAN_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc_r;
   logic [DUTY_W-1:0]  pwm_cnt_r;
   logic               cfg_ready_r;
   logic               tick_s;
   logic               accept_s;

   assign tick_s   = (presc_r == PRESC_LAST);
   assign accept_s = cfg_valid && cfg_ready_r;

   // Shared time bases and the post-reset ready flag
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r     <= {PRESC_W{1'b0}};
         pwm_cnt_r   <= {DUTY_W{1'b0}};
         cfg_ready_r <= 1'b0;
      end else begin
         presc_r     <= tick_s ? {PRESC_W{1'b0}} : presc_r + PRESC_W'(1);
         pwm_cnt_r   <= pwm_cnt_r + DUTY_W'(1);
         cfg_ready_r <= 1'b1;
      end
   end

   assign cfg_ready = cfg_ready_r;

   // Out-of-range channel numbers match no instance and are dropped here.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      logic wr_en_s;
      assign wr_en_s = accept_s && (cfg_chan == CHAN_W'(c));

      led_chan #(
         .PER_W  (PER_W),
         .DUTY_W (DUTY_W)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick_s),
         .pwm_cnt   (pwm_cnt_r),
         .wr_en     (wr_en_s),
         .wr_mode   (cfg_mode),
         .wr_period (cfg_period),
         .wr_duty   (cfg_duty),
         .led       (led_out[c])
      );
   end

endmodule
